// File: rtl/spi_slave_tx.sv
// spi_slave_tx
// SPI slave transmitter (MISO side) that runs entirely on the system clock.
// sck and ss are oversampled through synchronisers. All four SPI modes and
// both bit orders are supported. Outgoing words are buffered in a small FIFO
// behind a valid/ready handshake, so several words can go out back-to-back
// within one ss assertion.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sck        SPI clock from the master (asynchronous)
//   ss         slave select, active-low (asynchronous)
//   cpol       clock idle level, latched at frame start
//   cpha       0: sample on leading edge, 1: sample on trailing edge
//   tx         registered MISO data
//   data       word to enqueue
//   data_valid data is valid this cycle
//   data_ready FIFO not full; a push happens on data_valid && data_ready
//   busy       a frame is active
//   word_done  one-cycle pulse when the last bit of a word is sampled
//   underrun   one-cycle pulse when a word is popped from an empty FIFO
module spi_slave_tx #(
  parameter int DATA_LENGTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   cpol,
  input  logic                   cpha,
  output logic                   tx,
  input  logic [DATA_LENGTH-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   busy,
  output logic                   word_done,
  output logic                   underrun
);

  localparam int PTRW = $clog2(DATA_LENGTH + 1);
  localparam int SCW  = $clog2(DATA_LENGTH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [PTRW-1:0] PTR_END   = PTRW'(DATA_LENGTH);
  localparam logic [PTRW-1:0] PTR_ONE   = PTRW'(1);
  localparam logic [SCW-1:0]  SCNT_LAST = SCW'(DATA_LENGTH - 1);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Words are stored in transmit order so the shifter always walks
  // from index 0 upward regardless of LSB_FIRST.
  function automatic logic [DATA_LENGTH-1:0] txOrder(input logic [DATA_LENGTH-1:0] w);
    logic [DATA_LENGTH-1:0] r;
    r = w;
    if (!LSB_FIRST) begin
      for (int i = 0; i < DATA_LENGTH; i++) begin
        r[i] = w[DATA_LENGTH-1-i];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Synchronisers for sck and ss, plus one extra register per signal used
  // for edge detection.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sckSync_q;
  logic [SYNC_STAGES-1:0] ssSync_q;
  logic                   sckPrev_q;
  logic                   ssPrev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckSync_q <= '0;
      ssSync_q  <= '0;
      sckPrev_q <= 1'b0;
      ssPrev_q  <= 1'b0;
    end else begin
      sckSync_q <= {sckSync_q[SYNC_STAGES-2:0], sck};
      ssSync_q  <= {ssSync_q[SYNC_STAGES-2:0], ss};
      sckPrev_q <= sckSync_q[SYNC_STAGES-1];
      ssPrev_q  <= ssSync_q[SYNC_STAGES-1];
    end
  end

  logic sckS;
  logic ssS;
  logic ssFall;
  logic riseEdge;
  logic fallEdge;
  logic leadEdge;
  logic trailEdge;
  logic shiftEdge;
  logic sampleEdge;
  logic cpol_q;
  logic cpha_q;

  assign sckS     = sckSync_q[SYNC_STAGES-1];
  assign ssS      = ssSync_q[SYNC_STAGES-1];
  assign ssFall   = ssPrev_q & ~ssS;
  assign riseEdge = sckS & ~sckPrev_q;
  assign fallEdge = ~sckS & sckPrev_q;

  // Edge roles come from the mode latched at frame start, so the mode pins
  // can move freely during a frame without affecting it.
  assign leadEdge   = cpol_q ? fallEdge : riseEdge;
  assign trailEdge  = cpol_q ? riseEdge : fallEdge;
  assign shiftEdge  = cpha_q ? leadEdge : trailEdge;
  assign sampleEdge = cpha_q ? trailEdge : leadEdge;

  // ---------------------------------------------------------------------
  // Word FIFO. There is no bypass: a pop while the FIFO is empty is an
  // underrun, even if a push happens in the same cycle.
  // ---------------------------------------------------------------------
  logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wrPtr_q;
  logic [AW-1:0]          rdPtr_q;
  logic [CW-1:0]          count_q;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   pushEn;
  logic                   popReq;
  logic                   popEn;
  logic [DATA_LENGTH-1:0] loadWord;

  assign fifoFull   = (count_q == FULL_CNT);
  assign fifoEmpty  = (count_q == '0);
  assign data_ready = !fifoFull;
  assign pushEn     = data_valid && !fifoFull;
  assign popEn      = popReq && !fifoEmpty;
  assign loadWord   = fifoEmpty ? '0 : txOrder(mem_q[rdPtr_q]);

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM: state register.
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic                   tx_q, tx_d;
  logic [PTRW-1:0]        ptr_q, ptr_d;
  logic [SCW-1:0]         scnt_q, scnt_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic                   cpol_d;
  logic                   cpha_d;
  logic                   wordDone_q, wordDone_d;
  logic                   underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b0;
      ptr_q      <= '0;
      scnt_q     <= '0;
      shift_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      wordDone_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      scnt_q     <= scnt_d;
      shift_q    <= shift_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      wordDone_q <= wordDone_d;
      underrun_q <= popReq && fifoEmpty;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM: next state. ptr is the index of the next bit to drive;
  // ptr == DATA_LENGTH means the current word is fully shifted out, so the
  // next shift edge fetches a fresh word. scnt counts sampled bits
  // independently to time word_done.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    scnt_d     = scnt_q;
    shift_d    = shift_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    wordDone_d = 1'b0;
    popReq     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b0;
        ptr_d  = '0;
        scnt_d = '0;
        if (ssFall) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          popReq  = 1'b1;
          shift_d = loadWord;
          state_d = ACTIVE;
          // With cpha=0 the master samples on the very first edge, so the
          // first bit must already be on the line.
          if (!cpha) begin
            tx_d  = loadWord[0];
            ptr_d = PTR_ONE;
          end
        end
      end

      ACTIVE: begin
        if (ssS) begin
          state_d = IDLE;
          tx_d    = 1'b0;
          ptr_d   = '0;
          scnt_d  = '0;
        end else begin
          if (shiftEdge) begin
            if (ptr_q < PTR_END) begin
              tx_d  = shift_q[ptr_q[SCW-1:0]];
              ptr_d = ptr_q + 1'b1;
            end else begin
              popReq  = 1'b1;
              shift_d = loadWord;
              tx_d    = loadWord[0];
              ptr_d   = PTR_ONE;
            end
          end
          if (sampleEdge) begin
            if (scnt_q == SCNT_LAST) begin
              scnt_d     = '0;
              wordDone_d = 1'b1;
            end else begin
              scnt_d = scnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q == ACTIVE);
  assign word_done = wordDone_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx
// Self-checking bench for spi_slave_tx. Two instances share sck/ss/mode pins
// and the push interface: dut0 sends LSB first, dut1 sends MSB first. The
// bench plays the SPI master at f_clk/16 and keeps a scoreboard queue of
// pushed words; every pop the DUT performs is mirrored by a pop from the
// queue (or an expected underrun when it is empty).
module tb_spi_slave_tx;

  localparam int DL    = 8;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck   = 1'b0;
  logic       ss    = 1'b1;
  logic       cpol  = 1'b0;
  logic       cpha  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       dv    = 1'b0;

  logic tx0, ready0, busy0, wd0, ur0;
  logic tx1, ready1, busy1, wd1, ur1;

  spi_slave_tx #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ss(ss), .cpol(cpol), .cpha(cpha),
    .tx(tx0), .data(data), .data_valid(dv), .data_ready(ready0),
    .busy(busy0), .word_done(wd0), .underrun(ur0)
  );

  spi_slave_tx #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ss(ss), .cpol(cpol), .cpha(cpha),
    .tx(tx1), .data(data), .data_valid(dv), .data_ready(ready1),
    .busy(busy1), .word_done(wd1), .underrun(ur1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Pulse counters, sampled on the falling edge away from DUT updates.
  int wdCnt0 = 0, urCnt0 = 0, wdCnt1 = 0, urCnt1 = 0;
  always @(negedge clk) begin
    if (wd0) wdCnt0++;
    if (ur0) urCnt0++;
    if (wd1) wdCnt1++;
    if (ur1) urCnt1++;
  end

  // Scoreboard.
  logic [7:0] modelQ[$];
  int         expUr;

  function automatic logic [7:0] modelPop();
    if (modelQ.size() > 0) return modelQ.pop_front();
    expUr++;
    return 8'h00;
  endfunction

  // Frame capture buffers filled by runFrame.
  logic [7:0] rx0 [8];
  logic [7:0] rx1 [8];
  logic       latEarly [64];
  logic       latLate [64];
  logic       busyMid;

  task automatic pushWord(input logic [7:0] w);
    @(negedge clk);
    data = w;
    dv   = 1'b1;
    if (modelQ.size() < DEPTH) modelQ.push_back(w);
    @(negedge clk);
    dv = 1'b0;
  endtask

  // Master model: half sck period is 8 clk cycles. After each shift edge tx
  // is captured 2 and 3 clk cycles later to observe the update latency.
  task automatic runFrame(input logic cp, input logic ch, input int nBits);
    cpol = cp;
    cpha = ch;
    sck  = cp;
    repeat (8) @(negedge clk);
    for (int w = 0; w < 8; w++) begin
      rx0[w] = 8'h00;
      rx1[w] = 8'h00;
    end
    ss = 1'b0;
    repeat (8) @(negedge clk);
    busyMid = busy0;
    for (int j = 0; j < nBits; j++) begin
      if (!ch) begin
        rx0[j/8][j%8]     = tx0;
        rx1[j/8][7-(j%8)] = tx1;
        sck = ~sck;
        repeat (8) @(negedge clk);
        sck = ~sck;
        repeat (2) @(negedge clk);
        latEarly[j] = tx0;
        @(negedge clk);
        latLate[j] = tx0;
        repeat (5) @(negedge clk);
      end else begin
        sck = ~sck;
        repeat (2) @(negedge clk);
        latEarly[j] = tx0;
        @(negedge clk);
        latLate[j] = tx0;
        repeat (5) @(negedge clk);
        rx0[j/8][j%8]     = tx0;
        rx1[j/8][7-(j%8)] = tx1;
        sck = ~sck;
        repeat (8) @(negedge clk);
      end
    end
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    obs = {tx0, busy0, wd0, ur0, ready0, tx1, busy1, wd1, ur1, ready1};
    checks++;
    if (obs !== 10'b00001_00001) $display("[TB] FAIL reset_during: got %b expected %b", obs, 10'b00001_00001);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    obs = {tx0, busy0, wd0, ur0, ready0, tx1, busy1, wd1, ur1, ready1};
    checks++;
    if (obs !== 10'b00001_00001) $display("[TB] FAIL reset_after: got %b expected %b", obs, 10'b00001_00001);
    else passes++;
  endtask

  // All four modes, one word each, with latency checks on shift edges.
  task automatic test_modes();
    logic [7:0] w, e;
    logic       cp, ch, expE, expL;
    int         wdB, urB, urB1;
    for (int m = 0; m < 4; m++) begin
      cp = (m >= 2);
      ch = (m % 2 == 1);
      w  = (m == 0) ? 8'hA5 : 8'h3C;
      pushWord(w);
      expUr = 0;
      e = modelPop();
      if (!ch) void'(modelPop());  // last trailing edge fetches a further word
      wdB = wdCnt0; urB = urCnt0; urB1 = urCnt1;
      runFrame(cp, ch, 8);
      checks++;
      if (rx0[0] !== e) $display("[TB] FAIL mode%0d_lsb_word: got %h expected %h", m, rx0[0], e);
      else passes++;
      checks++;
      if (rx1[0] !== e) $display("[TB] FAIL mode%0d_msb_word: got %h expected %h", m, rx1[0], e);
      else passes++;
      checks++;
      if (wdCnt0 - wdB !== 1) $display("[TB] FAIL mode%0d_word_done: got %0d expected 1", m, wdCnt0 - wdB);
      else passes++;
      checks++;
      if ((urCnt0 - urB !== expUr) || (urCnt1 - urB1 !== expUr))
        $display("[TB] FAIL mode%0d_underrun: got %0d/%0d expected %0d", m, urCnt0 - urB, urCnt1 - urB1, expUr);
      else passes++;
      checks++;
      if ({busyMid, busy0, tx0} !== 3'b100) $display("[TB] FAIL mode%0d_busy_tx: got %b expected 100", m, {busyMid, busy0, tx0});
      else passes++;
      for (int j = 0; j < 8; j++) begin
        if (ch || j < 7) begin
          if (ch) begin
            expE = (j == 0) ? 1'b0 : e[j-1];
            expL = e[j];
          end else begin
            expE = e[j];
            expL = e[j+1];
          end
          checks++;
          if ({latEarly[j], latLate[j]} !== {expE, expL})
            $display("[TB] FAIL mode%0d_latency_bit%0d: got %b expected %b", m, j, {latEarly[j], latLate[j]}, {expE, expL});
          else passes++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [3];
    int         wdB, urB;
    pushWord(8'h11);
    pushWord(8'h22);
    pushWord(8'h33);
    checks++;
    if ({ready0, ready1} !== {2{modelQ.size() < DEPTH}}) $display("[TB] FAIL b2b_ready_before: got %b expected 11", {ready0, ready1});
    else passes++;
    expUr = 0;
    for (int i = 0; i < 3; i++) e[i] = modelPop();
    void'(modelPop());
    wdB = wdCnt0; urB = urCnt0;
    runFrame(1'b0, 1'b0, 24);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rx0[i], rx1[i]} !== {e[i], e[i]}) $display("[TB] FAIL b2b_word%0d: got %h/%h expected %h", i, rx0[i], rx1[i], e[i]);
      else passes++;
    end
    checks++;
    if (wdCnt0 - wdB !== 3) $display("[TB] FAIL b2b_word_done: got %0d expected 3", wdCnt0 - wdB);
    else passes++;
    checks++;
    if (urCnt0 - urB !== expUr) $display("[TB] FAIL b2b_underrun: got %0d expected %0d", urCnt0 - urB, expUr);
    else passes++;
    checks++;
    if (ready0 !== 1'b1) $display("[TB] FAIL b2b_ready_after: got %b expected 1", ready0);
    else passes++;
  endtask

  task automatic test_underrun();
    logic [7:0] e;
    int         urB, wdB;
    expUr = 0;
    e = modelPop();
    urB = urCnt0; wdB = wdCnt0;
    runFrame(1'b0, 1'b1, 8);
    checks++;
    if ({rx0[0], rx1[0]} !== {e, e}) $display("[TB] FAIL underrun_word: got %h/%h expected %h", rx0[0], rx1[0], e);
    else passes++;
    checks++;
    if ({urCnt0 - urB, wdCnt0 - wdB} !== {expUr, 32'sd1})
      $display("[TB] FAIL underrun_pulses: got ur=%0d wd=%0d expected ur=%0d wd=1", urCnt0 - urB, wdCnt0 - wdB, expUr);
    else passes++;
    pushWord(8'h5A);
    expUr = 0;
    e = modelPop();
    urB = urCnt0;
    runFrame(1'b0, 1'b1, 8);
    checks++;
    if ({rx0[0], rx1[0]} !== {e, e}) $display("[TB] FAIL underrun_refill_word: got %h/%h expected %h", rx0[0], rx1[0], e);
    else passes++;
    checks++;
    if (urCnt0 - urB !== expUr) $display("[TB] FAIL underrun_refill_pulse: got %0d expected %0d", urCnt0 - urB, expUr);
    else passes++;
  endtask

  task automatic test_full();
    logic [7:0] e [4];
    logic       expReady;
    int         urB;
    for (int i = 0; i < 6; i++) begin
      pushWord(8'h81 + 8'(i));
      expReady = (modelQ.size() < DEPTH);
      checks++;
      if ({ready0, ready1} !== {expReady, expReady}) $display("[TB] FAIL full_ready_push%0d: got %b expected %b", i, {ready0, ready1}, {expReady, expReady});
      else passes++;
    end
    expUr = 0;
    for (int i = 0; i < 4; i++) e[i] = modelPop();
    urB = urCnt0;
    runFrame(1'b1, 1'b1, 32);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rx0[i], rx1[i]} !== {e[i], e[i]}) $display("[TB] FAIL full_word%0d: got %h/%h expected %h", i, rx0[i], rx1[i], e[i]);
      else passes++;
    end
    checks++;
    if (urCnt0 - urB !== expUr) $display("[TB] FAIL full_underrun: got %0d expected %0d", urCnt0 - urB, expUr);
    else passes++;
  endtask

  task automatic test_abort();
    logic [7:0] e;
    int         wdB, urB;
    pushWord(8'hF0);
    pushWord(8'h66);
    expUr = 0;
    void'(modelPop());  // partially sent word is discarded
    wdB = wdCnt0; urB = urCnt0;
    runFrame(1'b0, 1'b1, 3);
    checks++;
    if ({tx0, busy0, tx1, busy1} !== 4'b0000) $display("[TB] FAIL abort_idle: got %b expected 0000", {tx0, busy0, tx1, busy1});
    else passes++;
    checks++;
    if ({wdCnt0 - wdB, urCnt0 - urB} !== {32'sd0, expUr})
      $display("[TB] FAIL abort_pulses: got wd=%0d ur=%0d expected wd=0 ur=%0d", wdCnt0 - wdB, urCnt0 - urB, expUr);
    else passes++;
    e = modelPop();
    runFrame(1'b0, 1'b1, 8);
    checks++;
    if ({rx0[0], rx1[0]} !== {e, e}) $display("[TB] FAIL abort_next_word: got %h/%h expected %h", rx0[0], rx1[0], e);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    logic [9:0] obs;
    pushWord(8'hFF);
    expUr = 0;
    void'(modelPop());
    cpol = 1'b0; cpha = 1'b1; sck = 1'b0;
    repeat (8) @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
      repeat (8) @(negedge clk);
    end
    checks++;
    if ({tx0, busy0, tx1, busy1} !== 4'b1111) $display("[TB] FAIL midframe_active: got %b expected 1111", {tx0, busy0, tx1, busy1});
    else passes++;
    for (int i = 0; i < 4; i++) pushWord(8'hAA);
    checks++;
    if (ready0 !== (modelQ.size() < DEPTH)) $display("[TB] FAIL midframe_full: got %b expected %b", ready0, modelQ.size() < DEPTH);
    else passes++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {tx0, busy0, wd0, ur0, ready0, tx1, busy1, wd1, ur1, ready1};
    checks++;
    if (obs !== 10'b00001_00001) $display("[TB] FAIL midframe_reset: got %b expected %b", obs, 10'b00001_00001);
    else passes++;
    modelQ.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ss    = 1'b1;
    repeat (8) @(negedge clk);
    pushWord(8'h5A);
    e = modelPop();
    runFrame(1'b0, 1'b1, 8);
    checks++;
    if ({rx0[0], rx1[0]} !== {e, e}) $display("[TB] FAIL after_reset_word: got %h/%h expected %h", rx0[0], rx1[0], e);
    else passes++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_full();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx.md
# spi_slave_tx

Parametrised SPI slave transmitter (MISO side) running on the system clock. It replaces the SCK-clocked transmitter with a design that oversamples `sck`/`ss` through synchronisers, supports all four SPI modes and both bit orders, and buffers outgoing words in a small FIFO behind a valid/ready handshake. It sits between a system-clock producer (MCU-facing register logic or a DMA-style streamer) and the external SPI master, and supports back-to-back words within one `ss` assertion.

## Interface
- `DATA_LENGTH`, 8: bits per word, 2..32.
- `FIFO_DEPTH`, 4: words buffered, power of two, ≥2.
- `LSB_FIRST`, 1: 1 = bit 0 transmitted first, 0 = MSB first.
- `SYNC_STAGES`, 2: flip-flops per synchroniser on `sck` and `ss`, ≥2.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sck` input 1: SPI clock from the master, asynchronous to `clk`.
- `ss` input 1: slave select, active-low, asynchronous.
- `cpol` input 1: clock idle level; latched at frame start.
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start.
- `tx` output 1: MISO data, registered.
- `data` input DATA_LENGTH: word to enqueue.
- `data_valid` input 1: `data` is valid this cycle.
- `data_ready` output 1: FIFO not full; a push occurs when `data_valid && data_ready`.
- `busy` output 1: a frame is active (`ss` asserted and synchronised).
- `word_done` output 1: one-cycle pulse when the last bit of a word is sampled.
- `underrun` output 1: one-cycle pulse when a word is popped from an empty FIFO.

## Operation
- `sck` and `ss` each pass through SYNC_STAGES flip-flops. A further register holds the previous synchronised `sck` and updates every cycle.
- Edge definitions:
  - Leading edge: rising when `cpol`=0, falling when `cpol`=1. Trailing edge is the opposite.
  - Shift edge: trailing when `cpha`=0, leading when `cpha`=1.
  - Sample edge: the other edge.
- States:
  - IDLE: `tx`=0, `busy`=0, all `sck` edges ignored. A synchronised `ss` falling edge latches `cpol`/`cpha`, pops a word into the shift register and moves to ACTIVE.
    - `cpha`=0: `tx` is driven with bit 0 (first bit in order) in the same cycle; `ptr`=1.
    - `cpha`=1: `tx` holds; `ptr`=0.
  - ACTIVE: `busy`=1.
    - Shift edge with `ptr`<DATA_LENGTH: `tx` ← bit[`ptr`], `ptr`++.
    - Shift edge with `ptr`=DATA_LENGTH: pop the next word, `tx` ← its first bit, `ptr`=1.
    - Sample edge: `scnt`++. When `scnt` reaches DATA_LENGTH, pulse `word_done` and set `scnt`=0.
    - Synchronised `ss` high: return to IDLE, `tx`=0, `ptr`=`scnt`=0. A partially sent word is discarded, not requeued. FIFO contents are kept.
- Pop from an empty FIFO: the shift register loads all-zeros, `underrun` pulses, and the FIFO stays empty.
- FIFO:
  - `data_ready` = !full.
  - A push and a pop in the same cycle are both honoured when the FIFO is neither full nor empty.
  - No bypass: a pop while empty with a simultaneous push yields an underrun, and the pushed word is stored.
- Bit order is set by LSB_FIRST. Bit *k* is `data[k]` (LSB_FIRST=1) or `data[DATA_LENGTH-1-k]` (LSB_FIRST=0).
- Widths:
  - `ptr`: $clog2(DATA_LENGTH+1) bits.
  - `scnt`: $clog2(DATA_LENGTH) bits, wraps to 0 at DATA_LENGTH.
  - FIFO count: $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `tx`=0, `busy`=0, `word_done`=0, `underrun`=0, FIFO empty, `data_ready`=1, state IDLE, synchronisers 0.
- Latency from a pin edge of `sck`/`ss` to the `tx` update: SYNC_STAGES+1 `clk` cycles (3 for the defaults).
- Requirements on the master:
  - f_sck ≤ f_clk/(2·(SYNC_STAGES+2)).
  - `ss` setup to the first `sck` edge ≥ SYNC_STAGES+2 `clk` periods.
- `data_ready` reflects FIFO state registered at the start of the cycle. A pop frees a slot the following cycle.
- `word_done` and `underrun` are each exactly one `clk` cycle wide.
- Mode pins may change freely while IDLE; changes during ACTIVE have no effect.
- Reset asserted mid-frame: all outputs take their reset values immediately and FIFO contents are lost.

## Test plan
- Mode 0, LSB_FIRST=1, push 0xA5, 8 `sck` cycles at f_clk/16 → MISO bits sampled on rising edges are 1,0,1,0,0,1,0,1; one `word_done`; `busy` falls after `ss` rises.
- Modes 1, 2, 3 with LSB_FIRST=0, push 0x3C → master receives 0x3C in each mode; `tx` changes only SYNC_STAGES+1 cycles after shift edges.
- Push 0x11, 0x22, 0x33; a 24-bit frame with one `ss` assertion → 0x11, 0x22, 0x33 received back-to-back; three `word_done` pulses; `data_ready` stays 1.
- Empty FIFO, 8-bit frame → 0x00 received, one `underrun` pulse; then push 0x5A and run a new frame → 0x5A received.
- Push 6 words with FIFO_DEPTH=4 and no frame → `data_ready` drops after 4 pushes; words 5–6 are not accepted; frames return words 1–4 in order.
- `ss` deasserted after 3 bits of 0xF0, then a new frame → `tx`=0 in IDLE; the next frame sends the following FIFO word. Also assert `rst_n`=0 mid-frame → all outputs go to reset values within the same cycle.
